// File: rtl/touch_adc_responder.sv
// ============================================================================
//  Module      : touch_adc_responder
//  Description : Device-side model of the resistive-touch ADC serial port.
//                Decodes the control byte on ADC_DIN and returns X/Y values
//                on ADC_DOUT, with BUSY and pen interrupt.
//                Optional macro: TOUCH_ADC_8BIT_MODE_EN (honours MODE=1 as
//                an 8-bit conversion returning snapshot[11:4]).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module touch_adc_responder #(
    parameter logic [2:0] X_CH = 3'b101,
    parameter logic [2:0] Y_CH = 3'b001
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        ADC_DCLK,
    input  logic        SCEN,
    input  logic        ADC_DIN,
    input  logic        TOUCH,
    input  logic [11:0] X_VALUE,
    input  logic [11:0] Y_VALUE,
    output logic        ADC_DOUT,
    output logic        ADC_BUSY,
    output logic        ADC_PENIRQ_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_BUSY = 3'd2,
        S_DATA = 3'd3,
        S_TAIL = 3'd4
    } state_t;

    // Pin synchronizers; "prev" holds the last synchronized DCLK/SCEN for edge detection.
    logic dclk_s1_q, dclk_s2_q, dclk_prev_q;
    logic scen_s1_q, scen_s2_q, scen_prev_q;
    logic din_s1_q, din_s2_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            dclk_s1_q   <= 1'b0;
            dclk_s2_q   <= 1'b0;
            dclk_prev_q <= 1'b0;
            scen_s1_q   <= 1'b1;
            scen_s2_q   <= 1'b1;
            scen_prev_q <= 1'b1;
            din_s1_q    <= 1'b0;
            din_s2_q    <= 1'b0;
        end else begin
            dclk_s1_q   <= ADC_DCLK;
            dclk_s2_q   <= dclk_s1_q;
            dclk_prev_q <= dclk_s2_q;
            scen_s1_q   <= SCEN;
            scen_s2_q   <= scen_s1_q;
            scen_prev_q <= scen_s2_q;
            din_s1_q    <= ADC_DIN;
            din_s2_q    <= din_s1_q;
        end
    end

    logic dclk_rise, dclk_fall, scen_fall;
    assign dclk_rise = dclk_s2_q & ~dclk_prev_q;
    assign dclk_fall = ~dclk_s2_q & dclk_prev_q;
    assign scen_fall = ~scen_s2_q & scen_prev_q;

    state_t      state_q, state_d;
    logic        started_q, started_d;
    logic        cmd_done_q, cmd_done_d;
    logic [2:0]  cmd_cnt_q, cmd_cnt_d;
    logic [2:0]  chan_q, chan_d;
    logic [11:0] shift_q, shift_d;
    logic [3:0]  data_cnt_q, data_cnt_d;
    logic        dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        penirq_q, penirq_d;
    logic [3:0]  last_idx;

`ifdef TOUCH_ADC_8BIT_MODE_EN
    logic mode_q, mode_d;
    assign last_idx = mode_q ? 4'd7 : 4'd11;
`else
    assign last_idx = 4'd11;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= S_IDLE;
            started_q  <= 1'b0;
            cmd_done_q <= 1'b0;
            cmd_cnt_q  <= 3'd0;
            chan_q     <= 3'd0;
            shift_q    <= 12'h000;
            data_cnt_q <= 4'd0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            penirq_q   <= 1'b1;
`ifdef TOUCH_ADC_8BIT_MODE_EN
            mode_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            started_q  <= started_d;
            cmd_done_q <= cmd_done_d;
            cmd_cnt_q  <= cmd_cnt_d;
            chan_q     <= chan_d;
            shift_q    <= shift_d;
            data_cnt_q <= data_cnt_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            penirq_q   <= penirq_d;
`ifdef TOUCH_ADC_8BIT_MODE_EN
            mode_q     <= mode_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        started_d  = started_q;
        cmd_done_d = cmd_done_q;
        cmd_cnt_d  = cmd_cnt_q;
        chan_d     = chan_q;
        shift_d    = shift_q;
        data_cnt_d = data_cnt_q;
        dout_d     = dout_q;
        busy_d     = busy_q;
        penirq_d   = scen_s2_q ? ~TOUCH : 1'b1;
`ifdef TOUCH_ADC_8BIT_MODE_EN
        mode_d     = mode_q;
`endif

        // A deasserted chip select overrides any DCLK edge seen in the same cycle.
        if (scen_s2_q) begin
            state_d    = S_IDLE;
            started_d  = 1'b0;
            cmd_done_d = 1'b0;
            cmd_cnt_d  = 3'd0;
            chan_d     = 3'd0;
            shift_d    = 12'h000;
            data_cnt_d = 4'd0;
            dout_d     = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dout_d = 1'b0;
                    busy_d = 1'b0;
                    if (scen_fall) begin
                        state_d = S_CMD;
                    end
                end

                S_CMD: begin
                    if (dclk_rise && !cmd_done_q) begin
                        if (!started_q) begin
                            started_d = din_s2_q;
                        end else begin
                            if (cmd_cnt_q < 3'd3) begin
                                chan_d = {chan_q[1:0], din_s2_q};
                            end
`ifdef TOUCH_ADC_8BIT_MODE_EN
                            if (cmd_cnt_q == 3'd3) begin
                                mode_d = din_s2_q;
                            end
`endif
                            if (cmd_cnt_q == 3'd6) begin
                                cmd_done_d = 1'b1;
                                if (chan_q == X_CH) begin
                                    shift_d = X_VALUE;
                                end else if (chan_q == Y_CH) begin
                                    shift_d = Y_VALUE;
                                end else begin
                                    shift_d = 12'h000;
                                end
                            end else begin
                                cmd_cnt_d = cmd_cnt_q + 3'd1;
                            end
                        end
                    end else if (dclk_fall && cmd_done_q) begin
                        state_d = S_BUSY;
                        busy_d  = 1'b1;
                        dout_d  = 1'b0;
                    end
                end

                S_BUSY: begin
                    if (dclk_fall) begin
                        state_d    = S_DATA;
                        busy_d     = 1'b0;
                        dout_d     = shift_q[11];
                        shift_d    = {shift_q[10:0], 1'b0};
                        data_cnt_d = 4'd0;
                    end
                end

                S_DATA: begin
                    if (dclk_fall) begin
                        if (data_cnt_q == last_idx) begin
                            state_d = S_TAIL;
                            dout_d  = 1'b0;
                        end else begin
                            dout_d     = shift_q[11];
                            shift_d    = {shift_q[10:0], 1'b0};
                            data_cnt_d = data_cnt_q + 4'd1;
                        end
                    end
                end

                S_TAIL: begin
                    dout_d = 1'b0;
                    busy_d = 1'b0;
                end

                default: begin
                    state_d = S_IDLE;
                    dout_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign ADC_DOUT     = dout_q;
    assign ADC_BUSY     = busy_q;
    assign ADC_PENIRQ_n = penirq_q;

endmodule

`default_nettype wire

// File: tb/tb_touch_adc_responder.sv
// ============================================================================
//  Module      : tb_touch_adc_responder
//  Description : Scoreboard bench for touch_adc_responder; a master drives
//                frames, a monitor captures DOUT on DCLK rising edges.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_touch_adc_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dclk = 1'b0;
    logic        scen = 1'b1;
    logic        din = 1'b0;
    logic        touch = 1'b0;
    logic [11:0] xv = 12'h000;
    logic [11:0] yv = 12'h000;
    logic        dout, busy, penirq_n;

    always #5 clk = ~clk;

    touch_adc_responder dut (
        .CLK          (clk),
        .RST_n        (rst_n),
        .ADC_DCLK     (dclk),
        .SCEN         (scen),
        .ADC_DIN      (din),
        .TOUCH        (touch),
        .X_VALUE      (xv),
        .Y_VALUE      (yv),
        .ADC_DOUT     (dout),
        .ADC_BUSY     (busy),
        .ADC_PENIRQ_n (penirq_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [11:0] val;
        int          nbits;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic cap_bits[$];
    int   busy_cnt = 0;
    bit   seen_busy = 1'b0;
    bit   mon_en = 1'b1;

    task automatic expect_frame(input logic [11:0] val, input int nbits, input string name);
        exp_t e;
        e.val = val;
        e.nbits = nbits;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: acts as the master's receiver, sampling on its own DCLK rising edges.
    always @(negedge scen) begin
        cap_bits.delete();
        busy_cnt = 0;
        seen_busy = 1'b0;
    end

    always @(posedge dclk) begin
        if (!scen) begin
            if (busy) begin
                busy_cnt++;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                cap_bits.push_back(dout);
            end
        end
    end

    always @(posedge scen) begin
        if (mon_en && seen_busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                exp_t        e;
                logic [11:0] got;
                logic        tail;
                e = exp_q.pop_front();
                got = 12'h000;
                tail = 1'b0;
                for (int i = 0; i < e.nbits; i++) begin
                    if (i < cap_bits.size()) got = {got[10:0], cap_bits[i]};
                    else got = {got[10:0], 1'bx};
                end
                for (int i = e.nbits; i < cap_bits.size(); i++) tail = tail | cap_bits[i];
                check({e.name, "/busy_periods"}, busy_cnt, 32'd1);
                check({e.name, "/bit_count_ok"}, (cap_bits.size() >= e.nbits) ? 32'd1 : 32'd0, 32'd1);
                check({e.name, "/value"}, {20'h0, got}, {20'h0, e.val});
                check({e.name, "/tail_zero"}, {31'h0, tail}, 32'd0);
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One DCLK period (16 CLK): DIN set in the low phase, held through the high phase.
    task automatic dclk_bit(input logic b);
        din = b;
        clk_wait(8);
        dclk = 1'b1;
        clk_wait(8);
        dclk = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cmd, input int lead, input int post);
        scen = 1'b0;
        clk_wait(8);
        repeat (lead) dclk_bit(1'b0);
        for (int i = 7; i >= 0; i--) dclk_bit(cmd[i]);
        repeat (post) dclk_bit(1'b0);
        clk_wait(8);
        scen = 1'b1;
        clk_wait(16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        touch = 1'b1;
        clk_wait(3);
        check("reset_dout", dout, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_penirq", penirq_n, 1'b1);

        rst_n = 1'b1;
        clk_wait(3);
        check("penirq_touch", penirq_n, 1'b0);
        touch = 1'b0;
        clk_wait(1);
        check("penirq_release", penirq_n, 1'b1);
        touch = 1'b1;
        clk_wait(1);
        check("penirq_retouch", penirq_n, 1'b0);
        scen = 1'b0;
        clk_wait(4);
        check("penirq_scen_low", penirq_n, 1'b1);
        scen = 1'b1;
        clk_wait(4);
        check("penirq_scen_high", penirq_n, 1'b0);
        clk_wait(16);

        xv = 12'hA5C;
        expect_frame(12'hA5C, 12, "x_read");
        frame(8'b1101_0000, 0, 15);

        yv = 12'h123;
        expect_frame(12'h123, 12, "y_lead_zeros");
        frame(8'b1001_0000, 3, 15);

        expect_frame(12'h000, 12, "other_channel");
        frame(8'b1011_0000, 0, 15);

        xv = 12'hFFF;
        expect_frame(12'hFFF, 12, "snapshot");
        fork
            frame(8'b1101_0000, 0, 15);
            begin
                clk_wait(8 + 8 * 16 + 2 * 16 + 24);
                xv = 12'h000;
            end
        join

        xv = 12'hFFF;
        expect_frame(12'h01F, 5, "abort");
        scen = 1'b0;
        clk_wait(8);
        for (int i = 7; i >= 0; i--) dclk_bit(i == 7 || i == 6 || i == 4);
        dclk_bit(1'b0);
        repeat (4) dclk_bit(1'b0);
        din = 1'b0;
        clk_wait(8);
        dclk = 1'b1;
        clk_wait(4);
        check("abort_pre_dout", dout, 1'b1);
        scen = 1'b1;
        clk_wait(3);
        check("abort_dout", dout, 1'b0);
        check("abort_busy", busy, 1'b0);
        clk_wait(4);
        dclk = 1'b0;
        clk_wait(16);

        xv = 12'hA5C;
        expect_frame(12'hA5C, 12, "after_abort");
        frame(8'b1101_0000, 0, 15);

`ifdef TOUCH_ADC_8BIT_MODE_EN
        expect_frame(12'h0A5, 8, "mode8");
`else
        expect_frame(12'hA5C, 12, "mode_ignored");
`endif
        frame(8'b1101_1000, 0, 15);

        mon_en = 1'b0;
        xv = 12'hFFF;
        fork
            frame(8'b1101_0000, 0, 15);
            begin
                clk_wait(8 + 8 * 16 + 16 + 3 * 16 + 4);
                check("pre_reset_dout", dout, 1'b1);
                rst_n = 1'b0;
                #1;
                check("midreset_dout", dout, 1'b0);
                check("midreset_busy", busy, 1'b0);
                check("midreset_penirq", penirq_n, 1'b1);
                clk_wait(2);
                rst_n = 1'b1;
            end
        join
        clk_wait(16);
        mon_en = 1'b1;

        xv = 12'h5A3;
        expect_frame(12'h5A3, 12, "after_reset");
        frame(8'b1101_0000, 0, 15);

        clk_wait(8);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
